fetch_unit: RTL and testbench

- RV32 instruction-fetch stage, directly upstream of the fetch/decode pipeline register.
- Owns the PC register and issues in-order requests to the instruction memory, which has variable latency.
- Buffers returned words in a small FIFO and presents InstrF/PCPlus4F/ValidF to the F/D register.
- Honours StallF from the hazard unit and branch/jump redirects from execute, discarding wrong-path responses that are already in flight.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetched {instr, pc_plus4} entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_rd, r_wr;
  logic [CNT_W-1:0] r_cnt;
  logic w_pop, w_push;
  assign w_pop  = pop & (r_cnt != '0);
  assign w_push = push & ((r_cnt < CNT_W'(DEPTH)) | w_pop);
  assign dout   = r_mem[r_rd];
  assign count  = r_cnt;
  // pointer/count update; clear wins over push and pop
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage with credit-limited imem requests and redirect flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  logic [31:0]   r_pc, r_resp_pc, w_target;
  logic [CW-1:0] r_outst, r_drop, w_cnt, w_left;
  logic [CW:0]   w_used;
  logic          w_issue, w_push, w_pop;
  fetch_entry_t  w_din, w_head;
  assign w_target  = {PCTargetE[31:2], 2'b00};
  assign w_used    = {1'b0, r_outst} + {1'b0, w_cnt};
  assign imem_req  = reset & ~PCSrcE & (w_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = r_pc;
  assign w_issue   = imem_req & imem_gnt;
  assign w_left    = r_outst - CW'(imem_rvalid);
  assign ValidF    = w_cnt != '0;
  assign w_push    = imem_rvalid & (r_drop == '0) & ~PCSrcE;
  assign w_pop     = ValidF & ~StallF & ~PCSrcE;
  assign w_din     = '{instr: imem_rdata, pc_plus4: r_resp_pc + 32'd4};
  assign InstrF    = ValidF ? w_head.instr : NOP_INSTR;
  assign PCPlus4F  = ValidF ? w_head.pc_plus4 : 32'h0;
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (PCSrcE),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .count (w_cnt)
  );
  // fetch/response address tracking; a redirect marks every in-flight word as wrong-path
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_outst   <= '0;
      r_drop    <= '0;
    end else if (PCSrcE) begin
      r_pc      <= w_target;
      r_resp_pc <= w_target;
      r_outst   <= w_left;
      r_drop    <= w_left;
    end else begin
      if (w_issue) r_pc <= r_pc + 32'd4;
      r_outst <= w_left + CW'(w_issue);
      if (imem_rvalid && r_drop != '0) r_drop <= r_drop - 1'b1;
      if (imem_rvalid && r_drop == '0) r_resp_pc <= r_resp_pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table, directed and random checks of fetch_unit against a queue-based model
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0100;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk, reset, StallF, PCSrcE, imem_req, imem_gnt, imem_rvalid, ValidF;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrF, PCPlus4F;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned ep;
  } req_t;

  typedef struct {
    bit          rn, st, rd;
    logic [31:0] tg;
    bit          g, e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc4;
  } vec_t;

  req_t        pend[$];
  logic [31:0] bufq[$];
  logic [31:0] m_pc;
  int unsigned ep, cyc, lat;
  int          checks, failures;
  bit          obs_req;
  logic [31:0] obs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic step(input bit rn, input bit st, input bit rd, input logic [31:0] tg, input bit g);
    bit rv, ereq, pop;
    req_t e;
    reset = rn; StallF = st; PCSrcE = rd; PCTargetE = tg; imem_gnt = g;
    rv = pend.size() > 0 && pend[0].due <= cyc;
    imem_rvalid = rv;
    imem_rdata = rv ? mem_word(pend[0].addr) : $urandom;
    #1;
    if (rv && rn)
      assert (dut.r_outst != '0) else begin
        failures++;
        $display("FAIL protocol rvalid with outst=%0d", dut.r_outst);
      end
    ereq = rn && !rd && (pend.size() + bufq.size() < FIFO_DEPTH);
    obs_req = imem_req;
    obs_addr = imem_addr;
    chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
    if (ereq) chk("imem_addr", imem_addr, m_pc);
    pop = bufq.size() > 0 && !st;
    @(posedge clk);
    if (!rn) begin
      m_pc = RESET_PC; pend.delete(); bufq.delete(); ep++;
    end else if (rd) begin
      if (rv) void'(pend.pop_front());
      m_pc = {tg[31:2], 2'b00}; bufq.delete(); ep++;
    end else begin
      if (pop) void'(bufq.pop_front());
      if (rv) begin
        e = pend.pop_front();
        if (e.ep == ep) bufq.push_back(e.addr);
      end
      if (ereq && g) begin
        pend.push_back('{m_pc, cyc + lat, ep});
        m_pc += 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
    chk("ValidF", {31'b0, ValidF}, {31'b0, bufq.size() > 0});
    chk("InstrF", InstrF, bufq.size() > 0 ? mem_word(bufq[0]) : NOP);
    chk("PCPlus4F", PCPlus4F, bufq.size() > 0 ? bufq[0] + 32'd4 : 32'h0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ValidF && n < 20) begin step(1, 0, 0, 0, 1); n++; end
    chk("wait_valid", {31'b0, ValidF}, 32'd1);
  endtask

  task automatic first_req();
    int n = 0;
    do begin step(1, 0, 0, 0, 1); n++; end while (!obs_req && n < 20);
    chk("first_req", {31'b0, obs_req}, 32'd1);
  endtask

  vec_t vt[6];
  int unsigned exp_drop;

  initial begin
    checks = 0; failures = 0; cyc = 0; ep = 0; lat = 1; m_pc = RESET_PC;
    reset = 0; StallF = 0; PCSrcE = 0; PCTargetE = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    vt[0] = '{0, 0, 0, 0, 1, 0, 32'h0,   0, 32'h0};
    vt[1] = '{1, 0, 0, 0, 1, 1, 32'h100, 0, 32'h0};
    vt[2] = '{1, 0, 0, 0, 1, 1, 32'h104, 1, 32'h104};
    vt[3] = '{1, 0, 0, 0, 1, 0, 32'h0,   1, 32'h108};
    vt[4] = '{1, 0, 0, 0, 1, 1, 32'h108, 0, 32'h0};
    vt[5] = '{1, 0, 0, 0, 1, 1, 32'h10C, 1, 32'h10C};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      step(vt[i].rn, vt[i].st, vt[i].rd, vt[i].tg, vt[i].g);
      chk($sformatf("vec%0d_req", i), {31'b0, obs_req}, {31'b0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), obs_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, ValidF}, {31'b0, vt[i].e_valid});
      chk($sformatf("vec%0d_pc4", i), PCPlus4F, vt[i].e_pc4);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 1);
      chk("stall_hold", InstrF, mem_word(32'h108));
    end
    chk("stall_noreq", {31'b0, obs_req}, 32'd0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);

    lat = 3;
    step(1, 0, 1, 32'h300, 1);
    for (int n = 0; n < 10 && pend.size() < 2; n++) step(1, 1, 0, 0, 1);
    chk("lat3_outst", {30'b0, dut.r_outst}, 32'd2);
    exp_drop = pend.size() - ((pend.size() > 0 && pend[0].due <= cyc) ? 1 : 0);
    step(1, 0, 1, 32'h200, 1);
    chk("lat3_drop", {30'b0, dut.r_drop}, exp_drop);
    wait_valid();
    chk("lat3_pc4", PCPlus4F, 32'h204);
    chk("lat3_instr", InstrF, mem_word(32'h200));

    lat = 2;
    step(1, 0, 1, 32'h400, 1);
    for (int n = 0; n < 10 && !(pend.size() > 1 && pend[0].due <= cyc); n++) step(1, 1, 0, 0, 1);
    exp_drop = pend.size() - 1;
    step(1, 0, 1, 32'h500, 1);
    chk("samecyc_drop", {30'b0, dut.r_drop}, exp_drop);
    wait_valid();
    chk("samecyc_pc4", PCPlus4F, 32'h504);

    lat = 1;
    step(1, 0, 1, 32'h0000_0203, 1);
    first_req();
    chk("align_addr", obs_addr, 32'h200);
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    first_req();
    chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    first_req();
    chk("wrap_addr1", obs_addr, 32'h0);

    for (int n = 0; n < 10 && !(bufq.size() >= 1 && bufq.size() + pend.size() == 2); n++) step(1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("rst_valid", {31'b0, ValidF}, 32'd0);
    chk("rst_outst", {30'b0, dut.r_outst}, 32'd0);
    chk("rst_drop", {30'b0, dut.r_drop}, 32'd0);
    step(1, 0, 0, 0, 1);
    chk("rst_req", {31'b0, obs_req}, 32'd1);
    chk("rst_addr", obs_addr, RESET_PC);

    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
           $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
